// File: rtl/fft_bitrev_reorder.sv
// ============================================================================
// Module      : fft_bitrev_reorder
// Description : Ping-pong frame buffer converting bit-reversed FFT output order
//               into natural bin order over AXI-Stream style handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_bitrev_reorder #(
    parameter int WIDTH = 24,
    parameter int N     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] axis_i_tdata,
    input  logic             axis_i_tvalid,
    input  logic             axis_i_tlast,
    output logic             axis_i_tready,
    output logic [WIDTH-1:0] axis_o_tdata,
    output logic             axis_o_tvalid,
    output logic             axis_o_tlast,
    input  logic             axis_o_tready,
    output logic             frame_err
);

    localparam int             c_L       = $clog2(N);
    localparam logic [c_L-1:0] c_CNT_MAX = {c_L{1'b1}};

    function automatic logic [c_L-1:0] f_bitrev(input logic [c_L-1:0] a);
        logic [c_L-1:0] r;
        r = '0;
        for (int i = 0; i < c_L; i++) begin
            r[i] = a[c_L-1-i];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] r_mem [0:1][0:N-1];
    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [c_L-1:0]   r_wr_cnt;
    logic [c_L-1:0]   r_rd_cnt;
    logic [WIDTH-1:0] r_o_tdata;
    logic             r_o_tvalid;
    logic             r_o_tlast;
    logic             r_frame_err;

    logic             w_accept;
    logic             w_wr_last;
    logic             w_load;
    logic             w_rd_last;
    logic [1:0]       w_full_nxt;

    assign w_accept  = axis_i_tvalid && !r_full[r_wr_bank];
    assign w_wr_last = (r_wr_cnt == c_CNT_MAX);
    assign w_load    = r_full[r_rd_bank] && (!r_o_tvalid || axis_o_tready);
    assign w_rd_last = (r_rd_cnt == c_CNT_MAX);

    // A bank being filled is never the bank being drained, so set and clear
    // always target different bits and both apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_accept && w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_load && w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Sample memory carries no reset; stale contents are never read because
    // a bank is only drained after it has been completely rewritten.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_bank][f_bitrev(r_wr_cnt)] <= axis_i_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full      <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_o_tdata   <= '0;
            r_o_tvalid  <= 1'b0;
            r_o_tlast   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_full      <= w_full_nxt;
            // Error when tlast disagrees with the position inside the frame.
            r_frame_err <= w_accept && (axis_i_tlast != w_wr_last);

            if (w_accept) begin
                if (w_wr_last) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else if (axis_i_tlast) begin
                    r_wr_cnt  <= '0;
                end else begin
                    r_wr_cnt  <= r_wr_cnt + 1'b1;
                end
            end

            if (w_load) begin
                r_o_tdata  <= r_mem[r_rd_bank][r_rd_cnt];
                r_o_tvalid <= 1'b1;
                r_o_tlast  <= w_rd_last;
                if (w_rd_last) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_cnt  <= r_rd_cnt + 1'b1;
                end
            end else if (axis_o_tready) begin
                r_o_tvalid <= 1'b0;
            end
        end
    end

    assign axis_i_tready = !r_full[r_wr_bank];
    assign axis_o_tdata  = r_o_tdata;
    assign axis_o_tvalid = r_o_tvalid;
    assign axis_o_tlast  = r_o_tlast;
    assign frame_err     = r_frame_err;

endmodule

`default_nettype wire
